// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial adder.
// Parameter-derived constants are computed through functions so each instance gets its own values.
package digit_serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Legal only when the operand splits into whole digits.
  function automatic bit digit_fits(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module digit_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1] = (x[gi] & y[gi]) | (x[gi] & c[gi]) | (y[gi] & c[gi]);
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first, with a registered
// inter-digit carry and a start/busy/done handshake.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CNT_W      = cnt_bits(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  if (!digit_fits(WIDTH, DIGIT)) begin : g_bad_params
    $error("digit_serial_adder: DIGIT must divide WIDTH and WIDTH must be at least 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_c_msb;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] acc_shift;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .ci   (carry_q),
    .s    (slice_s),
    .co   (slice_co),
    .c_msb(slice_c_msb)
  );

  // Operands shift right to expose the next digit; results enter from the top.
  if (NUM_DIGITS == 1) begin : g_single
    assign a_shift   = '0;
    assign b_shift   = '0;
    assign acc_shift = slice_s;
  end else begin : g_multi
    assign a_shift   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_shift   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    assign acc_shift = {slice_s, acc_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        acc_d   = acc_shift;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          sum_d   = acc_shift;
          cout_d  = slice_co;
          ovf_d   = slice_c_msb ^ slice_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands DIGIT bits per clock using a registered carry between digits.
- Successor to the single-bit full-adder cells. It trades latency for area and adds a subtract mode, a start/busy/done handshake, carry-out and signed-overflow flags.
- Used by datapath blocks that need wide arithmetic without a full-width ripple chain.

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. DIGIT=WIDTH gives single-digit operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0: sum = a+b+cin. 1: sum = a-b, i.e. a + ~b + 1. Captured with the operands.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle onward.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow of the full WIDTH-bit result.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, cout, ovf and all internal registers are cleared to 0. A reset asserted mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: start=1 at a rising edge captures a, b (inverted if sub=1), and carry = sub ? 1 : cin. It clears the digit counter and moves to RUN.
  - RUN: each edge adds the current DIGIT-bit slice, least significant slice first. The slice sum is shifted into the result register and the slice carry-out is stored as the carry for the next digit. The counter increments.
  - On the edge that processes digit NUM_DIGITS-1: sum is loaded with the final result, cout gets the final carry, ovf = carry into MSB XOR carry out of MSB, done=1 for the next cycle, and state returns to IDLE.
- Latency: NUM_DIGITS = WIDTH/DIGIT.
  - If start is sampled at edge E, busy is high for the NUM_DIGITS cycles that follow E.
  - done is high in the cycle after edge E+NUM_DIGITS; busy is 0 in that cycle.
- Back-to-back operation: start may be asserted in the done cycle. It is accepted because the block is IDLE, so throughput is one result per NUM_DIGITS+1 cycles.
- start while busy is ignored (not queued). a, b, sub and cin may change freely after capture without affecting the result.
- done is never high for two consecutive cycles. busy and done are never high together.
- Width rules: the carry register is 1 bit and the counter is clog2(NUM_DIGITS) bits, minimum 1. Arithmetic is modulo 2^WIDTH; excess carry appears only on cout.
- If DIGIT=WIDTH, RUN lasts one cycle; the behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding (IDLE, RUN) and the derived constant NUM_DIGITS. It also holds a helper function that checks WIDTH % DIGIT == 0; elaboration fails otherwise.
- Sub-module digit_adder: combinational DIGIT-bit ripple adder.
  - Inputs: x, y, ci.
  - Outputs: s, co, and c_msb (carry into the top bit), used for ovf on the final digit.
  - Instantiated once; the top level holds all sequential logic.

Test Plan:
- WIDTH=16, DIGIT=4, add a=0x1234, b=0x4321, cin=0 -> done 5 cycles after start edge (4 busy cycles); sum=0x5555, cout=0, ovf=0.
- add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then add a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- sub a=0x0005, b=0x0007 with cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Then sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Pulse start again in busy cycle 2 with different operands -> ignored: exactly one done, carrying the first result. Then assert start in the done cycle -> accepted, and a second done follows 5 cycles later.
- Drop rst_n in busy cycle 3 -> busy, done, sum, cout and ovf go to 0 immediately, with no done. After release, a new start gives a correct result.
- WIDTH=8, DIGIT=8, add 0xC8+0x64 -> busy for 1 cycle; sum=0x2C, cout=1, ovf=0.
